// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_pkg
// Purpose  : Shared types and constants for the I2C master bit engine:
//            command codes, engine states, quarter-bit phases, widths.
// Revision : 1.0 - initial release
// ============================================================================
package i2c_pkg;

  localparam int CMD_WIDTH  = 3;
  localparam int DATA_WIDTH = 8;

  // Bit counter spans 0..8 (eight data bits plus the ACK slot)
  localparam int                     C_BITCNT_W = 4;
  localparam logic [C_BITCNT_W-1:0]  C_LAST_BIT = 4'd8;

  typedef enum logic [CMD_WIDTH-1:0] {
    CMD_START   = 3'd0,
    CMD_WRITE   = 3'd1,
    CMD_READ    = 3'd2,
    CMD_STOP    = 3'd3,
    CMD_RESTART = 3'd4
  } i2c_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_RESTART = 3'd2,
    ST_WRITE   = 3'd3,
    ST_READ    = 3'd4,
    ST_STOP    = 3'd5
  } i2c_state_e;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } i2c_phase_e;

  // Codes 5-7 are accepted but produce no bus activity
  function automatic logic is_nop(input logic [CMD_WIDTH-1:0] cmd);
    return (cmd > 3'd4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_bit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bit_ctrl
// Purpose  : I2C master bit engine. Executes START / RESTART / WRITE / READ /
//            STOP one at a time, advancing quarter-bit phases on i_tick and
//            driving open-drain enables for SCL and SDA.
// Config   : I2C_CLK_STRETCH_EN - when defined, the Q1->Q2 advance of any bit
//            that releases SCL waits for i_scl=1 (slave clock stretching).
// Revision : 1.0 - initial release
// ============================================================================
module i2c_bit_ctrl
  import i2c_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_tick,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [CMD_WIDTH-1:0]  i_cmd,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_ack_send,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_ack_rcvd,
  output logic                  o_done,
  output logic                  o_busy,
  input  logic                  i_scl,
  input  logic                  i_sda,
  output logic                  o_scl_oe,
  output logic                  o_sda_oe
);

  i2c_state_e            r_state, w_state_nxt;
  i2c_phase_e            r_phase, w_phase_nxt;
  logic [C_BITCNT_W-1:0] r_bitcnt, w_bitcnt_nxt;

  logic [DATA_WIDTH-1:0] r_shift;      // outgoing byte, MSB at top
  logic [DATA_WIDTH-1:0] r_rshift;     // incoming byte being assembled
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_ack_rcvd;
  logic                  r_ack_send;
  logic                  r_done;
  logic                  r_busy;
  logic                  r_scl_hold;   // last driven enables, held between commands
  logic                  r_sda_hold;

  logic w_accept;
  logic w_adv;
  logic w_data_st;
  logic w_last_bit;
  logic w_finish;
  logic w_bit_val;
  logic w_scl_oe;
  logic w_sda_oe;

  assign o_cmd_ready = (r_state == ST_IDLE);
  assign w_accept    = i_cmd_valid & o_cmd_ready;

`ifdef I2C_CLK_STRETCH_EN
  // Leaving Q1 of a bit that released SCL requires the line to actually be
  // high; START never pulls SCL low before Q1, so it is exempt.
  assign w_adv = i_tick & ((r_phase != Q1) | (r_state == ST_START) | i_scl);
`else
  logic w_unused_scl;
  assign w_unused_scl = i_scl;
  assign w_adv        = i_tick;
`endif

  assign w_data_st  = (r_state == ST_WRITE) | (r_state == ST_READ);
  assign w_last_bit = !w_data_st || (r_bitcnt == C_LAST_BIT);
  assign w_finish   = (r_state != ST_IDLE) && w_adv && (r_phase == Q3) && w_last_bit;

  // Logical SDA level of the current data bit (1 = released)
  always_comb begin
    w_bit_val = 1'b1;
    if ((r_state == ST_WRITE) && (r_bitcnt != C_LAST_BIT)) begin
      w_bit_val = r_shift[DATA_WIDTH-1];
    end else if ((r_state == ST_READ) && (r_bitcnt == C_LAST_BIT)) begin
      w_bit_val = r_ack_send;
    end
  end

  // State, phase and bit counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_phase  <= Q0;
      r_bitcnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_phase  <= w_phase_nxt;
      r_bitcnt <= w_bitcnt_nxt;
    end
  end

  // Next-state: command dispatch from idle, phase/bit sequencing otherwise
  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_bitcnt_nxt = r_bitcnt;
    if (r_state == ST_IDLE) begin
      w_phase_nxt  = Q0;
      w_bitcnt_nxt = '0;
      if (w_accept) begin
        case (i_cmd)
          CMD_START:   w_state_nxt = ST_START;
          CMD_WRITE:   w_state_nxt = ST_WRITE;
          CMD_READ:    w_state_nxt = ST_READ;
          CMD_STOP:    w_state_nxt = ST_STOP;
          CMD_RESTART: w_state_nxt = ST_RESTART;
          default:     w_state_nxt = ST_IDLE;
        endcase
      end
    end else if (w_adv) begin
      if (r_phase == Q3) begin
        w_phase_nxt = Q0;
        if (w_last_bit) begin
          w_state_nxt  = ST_IDLE;
          w_bitcnt_nxt = '0;
        end else begin
          w_bitcnt_nxt = r_bitcnt + 4'd1;
        end
      end else begin
        w_phase_nxt = i2c_phase_e'(r_phase + 2'd1);
      end
    end
  end

  // Open-drain enable patterns per state and quarter phase
  always_comb begin
    w_scl_oe = r_scl_hold;
    w_sda_oe = r_sda_hold;
    case (r_state)
      ST_START: begin
        w_scl_oe = (r_phase == Q3);
        w_sda_oe = (r_phase == Q2) || (r_phase == Q3);
      end
      ST_RESTART: begin
        w_scl_oe = (r_phase == Q0) || (r_phase == Q3);
        w_sda_oe = (r_phase == Q2) || (r_phase == Q3);
      end
      ST_STOP: begin
        w_scl_oe = (r_phase == Q0);
        w_sda_oe = (r_phase != Q3);
      end
      ST_WRITE, ST_READ: begin
        w_scl_oe = (r_phase == Q0) || (r_phase == Q3);
        w_sda_oe = ~w_bit_val;
      end
      default: ;
    endcase
  end

  // Remember the enables of the final phase so the bus holds between commands
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scl_hold <= 1'b0;
      r_sda_hold <= 1'b0;
    end else if (r_state != ST_IDLE) begin
      r_scl_hold <= w_scl_oe;
      r_sda_hold <= w_sda_oe;
    end
  end

  // Datapath: latch operands, sample SDA, shift bytes, flag completion
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift    <= '0;
      r_rshift   <= '0;
      r_rdata    <= '0;
      r_ack_rcvd <= 1'b0;
      r_ack_send <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_shift    <= i_wdata;
        r_ack_send <= i_ack_send;
        if (i_cmd == CMD_START) begin
          r_busy <= 1'b1;
        end
        if (is_nop(i_cmd)) begin
          r_done <= 1'b1;
        end
      end else if ((r_state != ST_IDLE) && w_adv) begin
        if (r_phase == Q2) begin
          if ((r_state == ST_WRITE) && (r_bitcnt == C_LAST_BIT)) begin
            r_ack_rcvd <= i_sda;
          end
          if ((r_state == ST_READ) && (r_bitcnt != C_LAST_BIT)) begin
            r_rshift <= {r_rshift[DATA_WIDTH-2:0], i_sda};
          end
        end
        if ((r_phase == Q3) && (r_state == ST_WRITE)) begin
          r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
        end
        if (w_finish) begin
          r_done <= 1'b1;
          if (r_state == ST_READ) begin
            r_rdata <= r_rshift;
          end
          if (r_state == ST_STOP) begin
            r_busy <= 1'b0;
          end
        end
      end
    end
  end

  assign o_scl_oe   = w_scl_oe;
  assign o_sda_oe   = w_sda_oe;
  assign o_rdata    = r_rdata;
  assign o_ack_rcvd = r_ack_rcvd;
  assign o_done     = r_done;
  assign o_busy     = r_busy;

endmodule
`default_nettype wire
